// File: rtl/cabin_pkg.sv
// cabin_pkg: shared engine/door command codes, sensor_door codes and door states.
package cabin_pkg;
    localparam logic [1:0] ENG_STOP   = 2'b00;
    localparam logic [1:0] ENG_UP     = 2'b01;
    localparam logic [1:0] ENG_DOWN   = 2'b10;
    localparam logic [1:0] ENG_HALT   = 2'b11;
    localparam logic [1:0] DOOR_HOLD  = 2'b00;
    localparam logic [1:0] DOOR_OPEN  = 2'b01;
    localparam logic [1:0] DOOR_CLOSE = 2'b10;
    localparam logic [1:0] DOOR_KEEP  = 2'b11;
    localparam logic [1:0] SD_CLOSED  = 2'b10;
    localparam logic [1:0] SD_OPEN    = 2'b01;
    localparam logic [1:0] SD_TRANSIT = 2'b00;

    typedef enum logic [1:0] {DS_CLOSED, DS_OPENING, DS_OPEN, DS_CLOSING} door_state_t;

    function automatic logic eng_moving(input logic [1:0] e);
        return e == ENG_UP || e == ENG_DOWN;
    endfunction
endpackage

// File: rtl/cabin_door.sv
// cabin_door: door FSM with stroke counter 0..DELAY_DOOR; open_ok carries the
// level/motion interlock decided by the cabin.
module cabin_door
    import cabin_pkg::*;
#(
    parameter int DELAY_DOOR = 10
) (
    input  logic       clock,
    input  logic       an_reset,
    input  logic [1:0] door,
    input  logic       open_ok,
    output logic       closed,
    output logic [1:0] sensor_door
);
    localparam int CW = $clog2(DELAY_DOOR + 1);

    door_state_t   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_up, cnt_dn;
    logic          opening, closing;

    always_ff @(posedge clock or negedge an_reset) begin
        if (!an_reset) begin
            state <= DS_CLOSED;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Reversals keep the current count, so the stroke retraces from where it is.
    always_comb begin
        cnt_up   = cnt + 1'b1;
        cnt_dn   = cnt - 1'b1;
        opening  = (state == DS_OPENING && door != DOOR_CLOSE) ||
                   (open_ok && (state == DS_CLOSED || state == DS_CLOSING));
        closing  = (state == DS_CLOSING && !open_ok) ||
                   (door == DOOR_CLOSE && (state == DS_OPEN || state == DS_OPENING));
        cnt_nx   = opening ? cnt_up : closing ? cnt_dn : cnt;
        state_nx = opening ? (cnt_up == CW'(DELAY_DOOR) ? DS_OPEN : DS_OPENING) :
                   closing ? (cnt_dn == '0 ? DS_CLOSED : DS_CLOSING) : state;
    end

    assign closed      = state == DS_CLOSED;
    assign sensor_door = state == DS_CLOSED ? SD_CLOSED : state == DS_OPEN ? SD_OPEN : SD_TRANSIT;
endmodule

// File: rtl/cabin_plant.sv
// cabin_plant: elevator cabin and door plant model with motion/door interlocks.
// Define CABIN_FAULT_EN to enable the sticky illegal-command fault flag.
module cabin_plant
    import cabin_pkg::*;
#(
    parameter int FLOORS       = 8,
    parameter int DELAY_ENGINE = 10,
    parameter int DELAY_DOOR   = 10
) (
    input  logic                      clock,
    input  logic                      an_reset,
    input  logic [1:0]                engine,
    input  logic [1:0]                door,
    output logic [1:0]                sensor_door,
    output logic                      sensor_up,
    output logic                      sensor_down,
    output logic [$clog2(FLOORS)-1:0] floor,
    output logic                      at_floor,
    output logic                      fault
);
    localparam int FW = $clog2(FLOORS);
    localparam int OW = $clog2(DELAY_ENGINE);

    logic [OW-1:0] offset, offset_nx;
    logic [FW-1:0] floor_nx;
    logic          closed, moving, open_ok, go_up, go_down, wrap_up, wrap_dn;

    cabin_door #(.DELAY_DOOR(DELAY_DOOR)) u_door (
        .clock       (clock),
        .an_reset    (an_reset),
        .door        (door),
        .open_ok     (open_ok),
        .closed      (closed),
        .sensor_door (sensor_door)
    );

    assign at_floor = offset == '0;

    // Position is floor plus a sub-floor offset; only a closed door lets it change.
    always_comb begin
        moving      = eng_moving(engine);
        sensor_up   = at_floor && floor == FW'(FLOORS - 1);
        sensor_down = at_floor && floor == '0;
        go_up       = engine == ENG_UP && closed && !sensor_up;
        go_down     = engine == ENG_DOWN && closed && !sensor_down;
        wrap_up     = offset == OW'(DELAY_ENGINE - 1);
        wrap_dn     = at_floor;
        offset_nx   = go_up ? (wrap_up ? '0 : offset + 1'b1) :
                      go_down ? (wrap_dn ? OW'(DELAY_ENGINE - 1) : offset - 1'b1) : offset;
        floor_nx    = (go_up && wrap_up) ? floor + 1'b1 : (go_down && wrap_dn) ? floor - 1'b1 : floor;
        open_ok     = door == DOOR_OPEN && at_floor && !moving;
    end

    always_ff @(posedge clock or negedge an_reset) begin
        if (!an_reset) begin
            floor  <= '0;
            offset <= '0;
        end else begin
            floor  <= floor_nx;
            offset <= offset_nx;
        end
    end

`ifdef CABIN_FAULT_EN
    logic illegal;

    assign illegal = (moving && !closed) || (engine == ENG_UP && sensor_up) ||
                     (engine == ENG_DOWN && sensor_down) ||
                     (door == DOOR_OPEN && (!at_floor || moving));

    always_ff @(posedge clock or negedge an_reset) begin
        if (!an_reset)
            fault <= 1'b0;
        else
            fault <= fault | illegal;
    end
`else
    assign fault = 1'b0;
`endif
endmodule

// File: doc/cabin_plant.md
CABIN_PLANT -- requirements
Module: cabin_plant

Interface
REQ-001 SHALL have parameter FLOORS, default 8, number of floors (>=2).
REQ-002 SHALL have parameter DELAY_ENGINE, default 10, clock cycles to travel one floor (>=2).
REQ-003 SHALL have parameter DELAY_DOOR, default 10, clock cycles for a full door stroke (>=2).
REQ-004 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port an_reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port engine  input  2  command: 00 stop, 01 up, 10 down, 11 stop.
REQ-007 SHALL have port door  input  2  command: 00 hold, 01 open, 10 close, 11 hold.
REQ-008 SHALL have port sensor_door  output  2  10 fully closed, 01 fully open, 00 in transit.
REQ-009 SHALL have port sensor_up  output  1  cabin level at top floor.
REQ-010 SHALL have port sensor_down  output  1  cabin level at floor 0.
REQ-011 SHALL have port floor  output  $clog2(FLOORS)  last floor passed or current floor.
REQ-012 SHALL have port at_floor  output  1  cabin level with a floor (offset 0).
REQ-013 SHALL have port fault  output  1  sticky illegal-command flag.

Function
REQ-014 SHALL hold cabin position as floor plus offset (0..DELAY_ENGINE-1); at_floor = (offset==0).
REQ-015 SHALL, when engine=01, door closed and not (at_floor and floor==FLOORS-1), increment offset each cycle; offset DELAY_ENGINE-1 -> 0 with floor+1.
REQ-016 SHALL, when engine=10, door closed and not (at_floor and floor==0), decrement offset; offset 0 -> DELAY_ENGINE-1 with floor-1.
REQ-017 SHALL allow direction reversal mid-segment with no penalty cycle; position retraces.
REQ-018 SHALL set sensor_up = at_floor & floor==FLOORS-1; sensor_down = at_floor & floor==0; combinational decode of state registers, no extra latency.
REQ-019 SHALL implement door FSM CLOSED, OPENING, OPEN, CLOSING with stroke counter 0..DELAY_DOOR.
REQ-020 SHALL accept door=01 only when at_floor and engine in {00,11}: CLOSED/CLOSING -> OPENING; counter +1 per cycle; DELAY_DOOR -> OPEN.
REQ-021 SHALL accept door=10 in OPEN/OPENING -> CLOSING; counter -1 per cycle; 0 -> CLOSED.
REQ-022 SHALL reverse OPENING<->CLOSING from current counter value (no restart).
REQ-023 SHALL stay in OPENING/CLOSING under door=00/11 (stroke continues to completion).
REQ-024 SHALL block cabin motion whenever door FSM is not CLOSED.
REQ-025 SHALL set fault on: engine move with door not CLOSED; up at top floor level; down at floor 0 level; door=01 while not at_floor or engine moving.
REQ-026 SHALL, when engine and door commands conflict in one cycle, apply the interlock rules independently; neither state advances illegally.

Reset
REQ-027 SHALL, on an_reset low, asynchronously set floor=0, offset=0, door CLOSED, counter=0, fault=0.
REQ-028 SHALL therefore present sensor_door=10, sensor_down=1, sensor_up=0, at_floor=1 during reset.
REQ-029 SHALL abandon any travel or stroke in progress on reset mid-operation.

Configuration
REQ-030 SHALL, with macro CABIN_FAULT_EN defined, implement the sticky fault flag per REQ-025.
REQ-031 SHALL, without CABIN_FAULT_EN, keep port fault tied to 0; interlocks of REQ-015..REQ-024 remain enforced.

Structure
REQ-032 SHALL place engine codes, door codes, sensor_door codes and door-state enumeration in shared package cabin_pkg.
REQ-033 SHALL implement the door FSM and stroke counter as sub-module cabin_door.

Verification (FLOORS=4, DELAY_ENGINE=10, DELAY_DOOR=10)
REQ-034 SHALL check: reset then engine=01 for 10 cycles -> floor=1, at_floor=1; 30 cycles total -> sensor_up=1, floor=3.
REQ-035 SHALL check: at floor 3, engine=01 held -> position unchanged, fault=1 (0 without CABIN_FAULT_EN).
REQ-036 SHALL check: at floor 0, door=01 for 10 cycles -> sensor_door 00 cycles 1..9, 01 at cycle 10; then engine=01 -> no motion, fault=1.
REQ-037 SHALL check: door=01 for 4 cycles then door=10 -> sensor_door=10 after exactly 4 further cycles.
REQ-038 SHALL check: engine=01 for 5 cycles then engine=10 for 5 cycles -> floor=0, at_floor=1, sensor_down=1.
REQ-039 SHALL check: an_reset low mid-travel at offset 6 -> immediate floor=0, at_floor=1, fault=0.
